m68k_bus_master: RTL

- Parametrised 68000 bus-cycle engine: the next generation of the single-word Pi-to-Amiga access state machine.
- Accepts one request at a time from the Pi register front-end over a valid/ready handshake and runs 68000 read/write cycles on the 16-bit Amiga bus.
- Cycles are timed by the CLK_7M edge strobes. Longword requests are split into two word cycles; BERR and DTACK-timeout terminations are reported with a status code.

---
 rtl/m68k_bus_master.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/m68k_bus_master.sv
// m68k_bus_master: 68000 bus-cycle engine; runs byte/word/long requests as word cycles timed by CLK_7M strobes.
// One request at a time; longwords split into two word cycles; BERR/timeout aborts reported via rsp_status.
module m68k_bus_master #(
    parameter int ADDR_WIDTH   = 24,
    parameter int TIMEOUT_CLKS = 64,
    parameter int TCW          = (TIMEOUT_CLKS < 1) ? 1 : $clog2(TIMEOUT_CLKS + 1)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  mc_clk_rising,
    input  logic                  mc_clk_falling,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_read,
    input  logic [2:0]            req_fc,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_status,
    output logic                  busy,
    input  logic                  dtack_n,
    input  logic                  berr_n,
    input  logic [15:0]           d_in,
    output logic [ADDR_WIDTH-2:0] a_out,
    output logic [2:0]            fc_out,
    output logic [15:0]           d_out,
    output logic                  a_oe,
    output logic                  fc_oe,
    output logic                  d_oe,
    output logic                  as_oe,
    output logic                  uds_oe,
    output logic                  lds_oe,
    output logic                  rw_oe
);
    localparam int AW1 = ADDR_WIDTH - 1;
    localparam logic [TCW-1:0] TLIM = TCW'((TIMEOUT_CLKS == 0) ? 0 : TIMEOUT_CLKS - 1);

    typedef enum logic [3:0] {IDLE, S1, S2, S3, S4, S5, S6, S7, ABT} state_t;

    state_t         state;
    logic [AW1-1:0] wa;
    logic           a0, rd, half;
    logic [1:0]     size, code;
    logic [2:0]     fc;
    logic [31:0]    wd;
    logic [TCW-1:0] tcnt;
    logic           fall, legal, uds_l, lds_l;

    // rising wins if both strobes ever coincide
    assign fall      = mc_clk_falling && !mc_clk_rising;
    assign legal     = (req_size != 2'd3) && !(req_size != 2'd0 && req_addr[0]);
    assign uds_l     = (size != 2'd0) || !a0;
    assign lds_l     = (size != 2'd0) || a0;
    assign req_ready = (state == IDLE) && !sys_rst;
    assign a_out     = wa;
    assign fc_out    = fc;
    assign d_out     = (size == 2'd0) ? {wd[7:0], wd[7:0]} : (size == 2'd2 && !half) ? wd[31:16] : wd[15:0];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
            {a_oe, fc_oe, d_oe, as_oe, uds_oe, lds_oe, rw_oe} <= '0;
            rsp_valid  <= 1'b0;
            rsp_status <= 2'd0;
            rsp_rdata  <= '0;
            busy       <= 1'b0;
            wa         <= '0;
            a0         <= 1'b0;
            rd         <= 1'b0;
            half       <= 1'b0;
            size       <= 2'd0;
            code       <= 2'd0;
            fc         <= 3'd0;
            wd         <= '0;
            tcnt       <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    wa   <= req_addr[ADDR_WIDTH-1:1];
                    a0   <= req_addr[0];
                    size <= req_size;
                    rd   <= req_read;
                    fc   <= req_fc;
                    wd   <= req_wdata;
                    half <= 1'b0;
                    if (legal) begin
                        state <= S1;
                        busy  <= 1'b1;
                        a_oe  <= 1'b1;
                        fc_oe <= 1'b1;
                    end else begin
                        rsp_valid  <= 1'b1;
                        rsp_status <= 2'd3;
                    end
                end
                S1: if (mc_clk_rising) begin
                    as_oe  <= 1'b1;
                    rw_oe  <= !rd;
                    uds_oe <= rd && uds_l;
                    lds_oe <= rd && lds_l;
                    state  <= S2;
                end
                S2: if (fall) begin
                    d_oe  <= !rd;
                    state <= S3;
                end
                S3: if (mc_clk_rising) begin
                    uds_oe <= uds_l;
                    lds_oe <= lds_l;
                    tcnt   <= '0;
                    state  <= S4;
                end
                S4: if (fall) begin
                    // BERR outranks DTACK; timeout only when neither is present
                    if (!berr_n || (TIMEOUT_CLKS != 0 && dtack_n && tcnt == TLIM)) begin
                        {as_oe, uds_oe, lds_oe, d_oe} <= '0;
                        code  <= berr_n ? 2'd2 : 2'd1;
                        state <= ABT;
                    end else if (!dtack_n) state <= S5;
                    else tcnt <= tcnt + TCW'(1);
                end
                S5: if (mc_clk_rising) state <= S6;
                S6: if (fall) begin
                    if (rd) rsp_rdata <= (size == 2'd2) ? (half ? {rsp_rdata[31:16], d_in} : {d_in, 16'h0000}) :
                                         (size == 2'd1) ? {16'h0000, d_in} : {24'h0, a0 ? d_in[7:0] : d_in[15:8]};
                    {as_oe, uds_oe, lds_oe} <= '0;
                    state <= S7;
                end
                S7: if (mc_clk_rising) begin
                    d_oe  <= 1'b0;
                    rw_oe <= 1'b0;
                    if (size == 2'd2 && !half) begin
                        half  <= 1'b1;
                        wa    <= wa + AW1'(1);
                        state <= S1;
                    end else begin
                        a_oe       <= 1'b0;
                        fc_oe      <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_status <= 2'd0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                ABT: if (mc_clk_rising) begin
                    a_oe       <= 1'b0;
                    fc_oe      <= 1'b0;
                    rw_oe      <= 1'b0;
                    rsp_valid  <= 1'b1;
                    rsp_status <= code;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
